// File: rtl/mem_req_ctrl_if.sv
// Bundle for mem_req_ctrl: CPU fetch and load/store handshakes plus the
// phase-clocked memory port. master = controller, slave = CPU/memory side.
interface mem_req_ctrl_if;
    logic        fetch_req;
    logic [7:0]  fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_inst;

    logic        ls_req;
    logic        ls_write;
    logic [1:0]  ls_size;
    logic        ls_signed;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic        mem_phase;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_sel;
    logic        mem_signed;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  fetch_req, fetch_addr,
        input  ls_req, ls_write, ls_size, ls_signed, ls_addr, ls_wdata,
        input  mem_rdata,
        output fetch_ack, fetch_inst,
        output ls_ack, ls_rdata, ls_err,
        output mem_phase, mem_read, mem_write, mem_sel, mem_signed,
        output mem_addr, mem_wdata
    );

    modport slave (
        output fetch_req, fetch_addr,
        output ls_req, ls_write, ls_size, ls_signed, ls_addr, ls_wdata,
        output mem_rdata,
        input  fetch_ack, fetch_inst,
        input  ls_ack, ls_rdata, ls_err,
        input  mem_phase, mem_read, mem_write, mem_sel, mem_signed,
        input  mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Arbitrates instruction fetches and load/stores onto a single phase-clocked
// memory port; every output is a register updated on the state transition.
module mem_req_ctrl (
    input logic            clk,
    input logic            rst,
    mem_req_ctrl_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] RD        = 3'd2;
    localparam logic [2:0] WR_SETUP  = 3'd3;
    localparam logic [2:0] WR_COMMIT = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    logic [2:0] state;
    logic [8:0] last_byte;
    logic       req_err;

    wire unused_fetch_lsb = ^bus.fetch_addr[1:0];

    // Illegal size, misalignment, or an access running past byte 63.
    always_comb begin
        last_byte = {1'b0, bus.ls_addr};
        req_err   = 1'b0;
        case (bus.ls_size)
            2'b00: begin
                last_byte = {1'b0, bus.ls_addr} + 9'd3;
                req_err   = (bus.ls_addr[1:0] != 2'b00);
            end
            2'b01: begin
                last_byte = {1'b0, bus.ls_addr} + 9'd1;
                req_err   = bus.ls_addr[0];
            end
            2'b10:   req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
        if (last_byte > 9'd63) begin
            req_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.mem_phase  <= 1'b1;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.mem_sel    <= 2'b00;
            bus.mem_signed <= 1'b0;
            bus.mem_addr   <= 8'h00;
            bus.mem_wdata  <= 32'h0;
            bus.fetch_ack  <= 1'b0;
            bus.fetch_inst <= 32'h0;
            bus.ls_ack     <= 1'b0;
            bus.ls_rdata   <= 32'h0;
            bus.ls_err     <= 1'b0;
        end else begin
            case (state)
                // Load/store wins; the request is captured into the memory-side registers here.
                IDLE: begin
                    if (bus.ls_req) begin
                        if (req_err) begin
                            state      <= DONE;
                            bus.ls_ack <= 1'b1;
                            bus.ls_err <= 1'b1;
                        end else begin
                            bus.mem_addr   <= bus.ls_addr;
                            bus.mem_sel    <= bus.ls_size;
                            bus.mem_signed <= bus.ls_signed;
                            if (bus.ls_write) begin
                                state         <= WR_SETUP;
                                bus.mem_phase <= 1'b1;
                                bus.mem_write <= 1'b1;
                                bus.mem_wdata <= bus.ls_wdata;
                            end else begin
                                state         <= RD;
                                bus.mem_phase <= 1'b0;
                                bus.mem_read  <= 1'b1;
                            end
                        end
                    end else if (bus.fetch_req) begin
                        state         <= FETCH;
                        bus.mem_phase <= 1'b1;
                        bus.mem_addr  <= {2'b00, bus.fetch_addr[7:2]};
                    end
                end
                FETCH: begin
                    state          <= DONE;
                    bus.fetch_inst <= bus.mem_rdata;
                    bus.fetch_ack  <= 1'b1;
                end
                RD: begin
                    state         <= DONE;
                    bus.ls_rdata  <= bus.mem_rdata;
                    bus.mem_read  <= 1'b0;
                    bus.mem_phase <= 1'b1;
                    bus.ls_ack    <= 1'b1;
                end
                // Falling phase with mem_write still high is the store commit.
                WR_SETUP: begin
                    state         <= WR_COMMIT;
                    bus.mem_phase <= 1'b0;
                end
                WR_COMMIT: begin
                    state         <= DONE;
                    bus.mem_write <= 1'b0;
                    bus.mem_phase <= 1'b1;
                    bus.ls_ack    <= 1'b1;
                end
                DONE: begin
                    state         <= IDLE;
                    bus.fetch_ack <= 1'b0;
                    bus.ls_ack    <= 1'b0;
                    bus.ls_err    <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    bus.mem_read  <= 1'b0;
                    bus.mem_write <= 1'b0;
                    bus.mem_phase <= 1'b1;
                    bus.fetch_ack <= 1'b0;
                    bus.ls_ack    <= 1'b0;
                    bus.ls_err    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: a phase-clocked memory model, a
// byte-array reference model and a decoupled ack monitor.
module tb_mem_req_ctrl;
    logic clk = 1'b0;
    logic rst;

    mem_req_ctrl_if bus ();

    mem_req_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ls;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          wr_cycles = 0;
    int          rd_cycles = 0;
    int          commits = 0;
    int          both_hi = 0;
    logic [31:0] imem    [64];
    logic [7:0]  dmem    [64];
    logic [7:0]  ref_mem [64];
    logic        prev_phase = 1'b1;

    // Memory device: combinational read, extension done here per mem_signed.
    logic [5:0] ma;
    logic [7:0] b0, b1, b2, b3;
    assign ma = bus.mem_addr[5:0];
    assign b0 = dmem[ma];
    assign b1 = dmem[ma + 6'd1];
    assign b2 = dmem[ma + 6'd2];
    assign b3 = dmem[ma + 6'd3];

    always_comb begin
        bus.mem_rdata = imem[ma];
        if (bus.mem_read) begin
            case (bus.mem_sel)
                2'b00:   bus.mem_rdata = {b3, b2, b1, b0};
                2'b01:   bus.mem_rdata = {{16{bus.mem_signed & b1[7]}}, b1, b0};
                default: bus.mem_rdata = {{24{bus.mem_signed & b0[7]}}, b0};
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A store lands only on a falling phase edge while mem_write is high.
    always @(posedge clk) begin
        #1;
        if (prev_phase && !bus.mem_phase && bus.mem_write) begin
            commits++;
            dmem[ma] = bus.mem_wdata[7:0];
            if (bus.mem_sel != 2'b10) dmem[ma + 6'd1] = bus.mem_wdata[15:8];
            if (bus.mem_sel == 2'b00) begin
                dmem[ma + 6'd2] = bus.mem_wdata[23:16];
                dmem[ma + 6'd3] = bus.mem_wdata[31:24];
            end
        end
        prev_phase = bus.mem_phase;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.mem_write) wr_cycles++;
            if (bus.mem_read) rd_cycles++;
            if (bus.mem_read && bus.mem_write) both_hi++;
            if (bus.fetch_ack || bus.ls_ack) begin
                if (bus.fetch_ack && bus.ls_ack) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL ack_overlap: both acks high at cycle %0d", cyc);
                end else if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_ack: ack at cycle %0d, none expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("ack_kind", {31'b0, bus.ls_ack}, {31'b0, e.is_ls});
                    check_output("ack_cycle", cyc, e.ack_cyc);
                    if (e.is_ls) check_output("ls_err", {31'b0, bus.ls_err}, {31'b0, e.err});
                    if (e.chk_data) begin
                        if (e.is_ls) check_output("ls_rdata", bus.ls_rdata, e.data);
                        else         check_output("fetch_inst", bus.fetch_inst, e.data);
                    end
                end
            end
        end
    end

    function automatic int nbytes_of(input logic [1:0] size);
        if (size == 2'b00) return 4;
        if (size == 2'b01) return 2;
        if (size == 2'b10) return 1;
        return 0;
    endfunction

    function automatic bit ref_err(input logic [1:0] size, input logic [7:0] addr);
        int n;
        n = nbytes_of(size);
        if (n == 0) return 1'b1;
        if ((int'(addr) % n) != 0) return 1'b1;
        return (int'(addr) + n - 1) > 63;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sgn,
                                             input logic [7:0] addr);
        longint v;
        int     n;
        v = 0;
        n = nbytes_of(size);
        for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [7:0] addr,
                             input logic [31:0] wdata);
        for (int i = 0; i < nbytes_of(size); i++) ref_mem[int'(addr) + i] = wdata[8 * i +: 8];
    endtask

    task automatic wait_ack(input bit want_ls, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            if (want_ls ? bus.ls_ack : bus.fetch_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL ack_timeout: got no %s ack, expected one within 10 cycles",
                     want_ls ? "ls" : "fetch");
        end
    endtask

    // Called at a negedge with the DUT idle; the next rising edge samples.
    task automatic apply_stimulus(input bit is_ls, input bit write, input logic [1:0] size,
                                  input bit sgn, input logic [7:0] addr,
                                  input logic [31:0] wdata);
        exp_t e;
        int   lat, w0, r0, c0;
        bit   err, ok;
        err        = is_ls && ref_err(size, addr);
        e.is_ls    = is_ls;
        e.err      = err;
        e.chk_data = 1'b0;
        e.data     = 32'h0;
        if (!is_ls) begin
            lat        = 2;
            e.chk_data = 1'b1;
            e.data     = imem[addr[7:2]];
        end else if (err) begin
            lat = 1;
        end else if (write) begin
            lat = 3;
            ref_store(size, addr, wdata);
        end else begin
            lat        = 2;
            e.chk_data = 1'b1;
            e.data     = ref_load(size, sgn, addr);
        end
        e.ack_cyc = cyc + lat;
        exp_q.push_back(e);
        w0 = wr_cycles;
        r0 = rd_cycles;
        c0 = commits;
        if (is_ls) begin
            bus.ls_req    = 1'b1;
            bus.ls_write  = write;
            bus.ls_size   = size;
            bus.ls_signed = sgn;
            bus.ls_addr   = addr;
            bus.ls_wdata  = wdata;
        end else begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = addr;
        end
        wait_ack(is_ls, ok);
        bus.ls_req    = 1'b0;
        bus.fetch_req = 1'b0;
        bus.ls_addr   = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        check_output("mem_write_cycles", wr_cycles - w0, (is_ls && write && !err) ? 2 : 0);
        check_output("store_commits", commits - c0, (is_ls && write && !err) ? 1 : 0);
        check_output("mem_read_cycles", rd_cycles - r0, (is_ls && !write && !err) ? 1 : 0);
    endtask

    initial begin
        exp_t ef, el;
        bit   ok;
        int   r, n, w0;
        logic [1:0]  size;
        logic [7:0]  addr;
        for (int i = 0; i < 64; i++) begin
            imem[i]    = $urandom;
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        imem[2]        = 32'h0000_0073;
        rst            = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = 8'h00;
        bus.ls_req     = 1'b0;
        bus.ls_write   = 1'b0;
        bus.ls_size    = 2'b00;
        bus.ls_signed  = 1'b0;
        bus.ls_addr    = 8'h00;
        bus.ls_wdata   = 32'h0;
        #17;
        check_output("rst_mem_phase", {31'b0, bus.mem_phase}, 32'h1);
        check_output("rst_mem_rw", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
        check_output("rst_acks", {29'b0, bus.fetch_ack, bus.ls_ack, bus.ls_err}, 32'h0);
        check_output("rst_fetch_inst", bus.fetch_inst, 32'h0);
        check_output("rst_ls_rdata", bus.ls_rdata, 32'h0);
        check_output("rst_mem_addr", {24'b0, bus.mem_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'h08, 32'h0);
        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 8'h0C, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h0C, 32'h0);
        apply_stimulus(1'b1, 1'b0, 2'b01, 1'b1, 8'h0E, 32'h0);
        apply_stimulus(1'b1, 1'b0, 2'b10, 1'b0, 8'h0F, 32'h0);

        // Load and fetch raised together: the load goes first, the fetch is resampled after DONE.
        el = '{is_ls: 1'b1, err: 1'b0, chk_data: 1'b1, data: ref_load(2'b00, 1'b0, 8'h04),
               ack_cyc: cyc + 2};
        ef = '{is_ls: 1'b0, err: 1'b0, chk_data: 1'b1, data: imem[9], ack_cyc: cyc + 5};
        exp_q.push_back(el);
        exp_q.push_back(ef);
        bus.ls_req     = 1'b1;
        bus.ls_write   = 1'b0;
        bus.ls_size    = 2'b00;
        bus.ls_addr    = 8'h04;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 8'h24;
        wait_ack(1'b1, ok);
        bus.ls_req = 1'b0;
        wait_ack(1'b0, ok);
        bus.fetch_req = 1'b0;
        @(posedge clk);
        @(negedge clk);

        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h02, 32'h0);
        apply_stimulus(1'b1, 1'b1, 2'b01, 1'b0, 8'h3F, 32'h1234_5678);
        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 8'h3D, 32'h1234_5678);
        apply_stimulus(1'b1, 1'b0, 2'b11, 1'b0, 8'h00, 32'h0);

        // Reset while a store sits in WR_SETUP must abandon it without a commit.
        w0             = commits;
        bus.ls_req     = 1'b1;
        bus.ls_write   = 1'b1;
        bus.ls_size    = 2'b00;
        bus.ls_addr    = 8'h20;
        bus.ls_wdata   = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        check_output("setup_mem_write", {31'b0, bus.mem_write}, 32'h1);
        rst = 1'b1;
        bus.ls_req = 1'b0;
        #1;
        check_output("abort_mem_write", {31'b0, bus.mem_write}, 32'h0);
        check_output("abort_mem_phase", {31'b0, bus.mem_phase}, 32'h1);
        check_output("abort_ls_rdata", bus.ls_rdata, 32'h0);
        check_output("abort_fetch_inst", bus.fetch_inst, 32'h0);
        @(posedge clk);
        #2;
        check_output("abort_no_ack", {30'b0, bus.fetch_ack, bus.ls_ack}, 32'h0);
        check_output("abort_no_commit", commits - w0, 0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h20, 32'h0);
        apply_stimulus(1'b1, 1'b1, 2'b00, 1'b0, 8'h10, 32'h0BAD_CAFE);
        apply_stimulus(1'b1, 1'b0, 2'b00, 1'b0, 8'h10, 32'h0);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                apply_stimulus(1'b0, 1'b0, 2'b00, 1'b0, 8'($urandom), 32'h0);
            end else begin
                size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                addr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
                n    = nbytes_of(size);
                if (n > 0 && $urandom_range(0, 3) != 0) addr = 8'((int'(addr) / n) * n);
                apply_stimulus(1'b1, 1'($urandom), size, 1'($urandom), addr, $urandom);
            end
        end

        check_output("queue_empty", exp_q.size(), 0);
        check_output("rd_wr_overlap", both_hi, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-002 SHALL have fetch_req in 1 (level, held until ack), fetch_addr in 8 (byte PC), fetch_ack out 1, fetch_inst out 32.
REQ-003 SHALL have ls_req in 1 (level, held until ack), ls_write in 1, ls_size in 2 (00 word, 01 half, 10 byte), ls_signed in 1, ls_addr in 8 (byte address), ls_wdata in 32.
REQ-004 SHALL have ls_ack out 1, ls_rdata out 32, ls_err out 1 (valid only with ls_ack).
REQ-005 SHALL have memory-side ports: mem_phase out 1 (drives the memory's phase clock; 1 = instruction phase), mem_read out 1, mem_write out 1, mem_sel out 2 (same encoding as ls_size), mem_signed out 1, mem_addr out 8, mem_wdata out 32, mem_rdata in 32.
REQ-006 SHALL register every output; no output is a combinational function of inputs.

Function
REQ-007 SHALL implement FSM states IDLE, FETCH, RD, WR_SETUP, WR_COMMIT, DONE.
REQ-008 IDLE: ls_req has priority over fetch_req; the request is latched at that edge; with no request, stay IDLE.
REQ-009 IDLE + ls_req + ls_err condition -> DONE with ls_err=1 and no memory access.
REQ-010 ls_err condition: ls_size=11; word with ls_addr[1:0]!=0; half with ls_addr[0]!=0; last accessed byte (ls_addr+size-1) >63.
REQ-011 IDLE + legal ls_req with ls_write=0 -> RD; with ls_write=1 -> WR_SETUP; IDLE + fetch_req only -> FETCH.
REQ-012 FETCH: mem_phase=1, mem_read=0, mem_write=0, mem_addr={2'b00,fetch_addr[7:2]}; capture mem_rdata into fetch_inst at the exiting edge; -> DONE.
REQ-013 RD: mem_phase=0, mem_read=1, mem_addr=ls_addr, mem_sel=ls_size, mem_signed=ls_signed; capture mem_rdata into ls_rdata at the exiting edge; -> DONE.
REQ-014 WR_SETUP: mem_phase=1, mem_write=1, mem_addr/mem_sel/mem_wdata valid; -> WR_COMMIT.
REQ-015 WR_COMMIT: mem_phase=0, mem_write=1; the 1->0 phase edge entering this state commits the store; -> DONE.
REQ-016 DONE: exactly one of fetch_ack/ls_ack high for one cycle; -> IDLE unconditionally; requests are not sampled in DONE.
REQ-017 mem_write SHALL be 0 on every 1->0 mem_phase transition other than entry to WR_COMMIT; mem_read and mem_write are never both 1.
REQ-018 Latency from the sampling edge in IDLE to the ack cycle: 2 cycles for fetch and load, 3 for store, 1 for error.
REQ-019 Outside their active states, mem_read=0, mem_write=0 and mem_phase=1; fetch_inst/ls_rdata hold their last captured value.
REQ-020 ls_rdata SHALL pass mem_rdata unchanged; sign/zero extension belongs to the memory per mem_signed.
REQ-021 Request inputs changing while not in IDLE SHALL be ignored; the latched request completes.

Reset
REQ-022 rst high SHALL asynchronously force IDLE, mem_phase=1, and all other outputs 0, including fetch_inst and ls_rdata.
REQ-023 Reset in WR_SETUP SHALL drop mem_write with mem_phase held at 1, so no store commits.
REQ-024 Reset in RD or FETCH SHALL discard the access with no ack.
REQ-025 The first request is sampled at the first clk rising edge after rst deasserts.

Verification
REQ-026 fetch_req=1, fetch_addr=0x08; mem_rdata returns 0x00000073 for mem_addr=2 -> fetch_inst=0x00000073 and fetch_ack pulse 2 cycles after sampling.
REQ-027 ls_req, ls_write=1, size=00, addr=0x0C, wdata=0xDEADBEEF -> mem_write high for exactly WR_SETUP+WR_COMMIT, single 1->0 phase edge, ls_ack at cycle 3, ls_err=0.
REQ-028 Simultaneous fetch_req and ls_req (load, addr 0x04) -> RD serviced first with ls_ack, then FETCH, then fetch_ack; no overlap.
REQ-029 ls_req size=00 addr=0x02, then size=01 addr=0x3F -> ls_ack+ls_err=1 one cycle after each, mem_read/mem_write never asserted.
REQ-030 rst asserted mid-WR_SETUP -> mem_write=0 and mem_phase=1 immediately, state IDLE, no ack; a store to 0x10 after reset completes normally.
